// File: rtl/ahb_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_bus_arbiter_if
// Brief    : Two-master AHB-Lite request side, shared bus side and slave
//            response bundle used by ahb_bus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

interface ahb_bus_arbiter_if #(
  parameter int WORD_WIDTH = `WORD_WIDTH
);
  // Master 0 request side
  logic [WORD_WIDTH-1:0] M0_HADDR;
  logic [1:0]            M0_HTRANS;
  logic                  M0_HWRITE;
  logic [2:0]            M0_HSIZE;
  logic [WORD_WIDTH-1:0] M0_HWDATA;
  logic                  M0_HREADY;
  logic                  M0_HRESP;
  // Master 1 request side
  logic [WORD_WIDTH-1:0] M1_HADDR;
  logic [1:0]            M1_HTRANS;
  logic                  M1_HWRITE;
  logic [2:0]            M1_HSIZE;
  logic [WORD_WIDTH-1:0] M1_HWDATA;
  logic                  M1_HREADY;
  logic                  M1_HRESP;
  // Read data broadcast to both masters
  logic [WORD_WIDTH-1:0] M_HRDATA;
  // Shared bus towards decoder and slaves
  logic [WORD_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [WORD_WIDTH-1:0] HWDATA;
  // Muxed slave response
  logic                  HREADY;
  logic                  HRESP;
  logic [WORD_WIDTH-1:0] HRDATA;

  // Arbiter view: consumes master requests and slave response, drives the rest
  modport slave (
    input  M0_HADDR, M0_HTRANS, M0_HWRITE, M0_HSIZE, M0_HWDATA,
    input  M1_HADDR, M1_HTRANS, M1_HWRITE, M1_HSIZE, M1_HWDATA,
    output M0_HREADY, M0_HRESP, M1_HREADY, M1_HRESP, M_HRDATA,
    output HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    input  HREADY, HRESP, HRDATA
  );

  // Environment view: masters and slave mux seen from outside the arbiter
  modport master (
    output M0_HADDR, M0_HTRANS, M0_HWRITE, M0_HSIZE, M0_HWDATA,
    output M1_HADDR, M1_HTRANS, M1_HWRITE, M1_HSIZE, M1_HWDATA,
    input  M0_HREADY, M0_HRESP, M1_HREADY, M1_HRESP, M_HRDATA,
    input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    output HREADY, HRESP, HRDATA
  );
endinterface

`default_nettype wire

// File: rtl/ahb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ahb_bus_arbiter
// Brief    : Two-master AHB-Lite round-robin arbiter. Losing requests are
//            latched and replayed; address phase is combinational.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module ahb_bus_arbiter #(
  parameter int         WORD_WIDTH    = `WORD_WIDTH,
  parameter logic [1:0] HTRANS_NONSEQ = 2'b10
) (
  input  logic             HCLK,
  input  logic             HRESET,
  ahb_bus_arbiter_if.slave bus
);

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  owner_t                dp_owner;
  logic                  last_grant;
  logic                  pend0, pend1;
  logic [WORD_WIDTH-1:0] hold_addr0, hold_addr1;
  logic                  hold_write0, hold_write1;
  logic [2:0]            hold_size0, hold_size1;

  logic                  m0_hready, m1_hready;
  logic                  live0, live1, req0, req1;
  logic                  grant0, grant1;
  logic [WORD_WIDTH-1:0] addr0, addr1;
  logic                  write0, write1;
  logic [2:0]            size0, size1;
  logic                  unused_htrans_lsb;

  // Only bit 1 of the master HTRANS is meaningful (SEQ collapses to NONSEQ)
  assign unused_htrans_lsb = &{1'b0, bus.M0_HTRANS[0], bus.M1_HTRANS[0]};

  // A pending master is stalled; the data-phase owner sees the slave ready
  assign m0_hready = pend0 ? 1'b0 : ((dp_owner == OWN_M0) ? bus.HREADY : 1'b1);
  assign m1_hready = pend1 ? 1'b0 : ((dp_owner == OWN_M1) ? bus.HREADY : 1'b1);

  assign live0 = bus.M0_HTRANS[1] & m0_hready;
  assign live1 = bus.M1_HTRANS[1] & m1_hready;
  assign req0  = pend0 | live0;
  assign req1  = pend1 | live1;

  // last_grant==1 means M1 went last, so M0 wins a tie (and vice versa)
  assign grant0 = bus.HREADY & req0 & (~req1 | last_grant);
  assign grant1 = bus.HREADY & req1 & (~req0 | ~last_grant);

  // Address-phase source per master: latched copy while pending, else live
  assign addr0  = pend0 ? hold_addr0  : bus.M0_HADDR;
  assign write0 = pend0 ? hold_write0 : bus.M0_HWRITE;
  assign size0  = pend0 ? hold_size0  : bus.M0_HSIZE;
  assign addr1  = pend1 ? hold_addr1  : bus.M1_HADDR;
  assign write1 = pend1 ? hold_write1 : bus.M1_HWRITE;
  assign size1  = pend1 ? hold_size1  : bus.M1_HSIZE;

  assign bus.HADDR  = grant1 ? addr1  : addr0;
  assign bus.HWRITE = grant1 ? write1 : write0;
  assign bus.HSIZE  = grant1 ? size1  : size0;
  assign bus.HTRANS = (grant0 | grant1) ? HTRANS_NONSEQ : HTRANS_IDLE;

  assign bus.M0_HREADY = m0_hready;
  assign bus.M1_HREADY = m1_hready;
  assign bus.M0_HRESP  = (dp_owner == OWN_M0) & bus.HRESP;
  assign bus.M1_HRESP  = (dp_owner == OWN_M1) & bus.HRESP;
  assign bus.M_HRDATA  = bus.HRDATA;

  // Write data follows whichever master owns the current data phase
  always_comb begin
    bus.HWDATA = '0;
    case (dp_owner)
      OWN_M0:  bus.HWDATA = bus.M0_HWDATA;
      OWN_M1:  bus.HWDATA = bus.M1_HWDATA;
      default: bus.HWDATA = '0;
    endcase
  end

  // Data-phase ownership, round-robin pointer and pending-request capture
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_owner    <= OWN_NONE;
      last_grant  <= 1'b1;
      pend0       <= 1'b0;
      pend1       <= 1'b0;
      hold_addr0  <= '0;
      hold_addr1  <= '0;
      hold_write0 <= 1'b0;
      hold_write1 <= 1'b0;
      hold_size0  <= '0;
      hold_size1  <= '0;
    end else begin
      if (bus.HREADY) begin
        if (grant0) begin
          dp_owner   <= OWN_M0;
          last_grant <= 1'b0;
        end else if (grant1) begin
          dp_owner   <= OWN_M1;
          last_grant <= 1'b1;
        end else begin
          dp_owner <= OWN_NONE;
        end
      end
      // live implies not pending, so a held request is never overwritten
      if (grant0) begin
        pend0 <= 1'b0;
      end else if (live0) begin
        pend0       <= 1'b1;
        hold_addr0  <= bus.M0_HADDR;
        hold_write0 <= bus.M0_HWRITE;
        hold_size0  <= bus.M0_HSIZE;
      end
      if (grant1) begin
        pend1 <= 1'b0;
      end else if (live1) begin
        pend1       <= 1'b1;
        hold_addr1  <= bus.M1_HADDR;
        hold_write1 <= bus.M1_HWRITE;
        hold_size1  <= bus.M1_HSIZE;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ahb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_bus_arbiter
// Brief    : Directed self-checking bench for ahb_bus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================

module tb_ahb_bus_arbiter;

  logic HCLK;
  logic HRESET;
  int   checks;
  int   failures;

  logic [31:0] rr_exp [6];

  ahb_bus_arbiter_if #(.WORD_WIDTH(32)) bus ();

  ahb_bus_arbiter #(.WORD_WIDTH(32), .HTRANS_NONSEQ(2'b10)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus.slave)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_m0(input logic [1:0] trans, input logic [31:0] addr,
                          input logic wr, input logic [2:0] size, input logic [31:0] wdata);
    bus.M0_HTRANS = trans;
    bus.M0_HADDR  = addr;
    bus.M0_HWRITE = wr;
    bus.M0_HSIZE  = size;
    bus.M0_HWDATA = wdata;
  endtask

  task automatic drive_m1(input logic [1:0] trans, input logic [31:0] addr,
                          input logic wr, input logic [2:0] size, input logic [31:0] wdata);
    bus.M1_HTRANS = trans;
    bus.M1_HADDR  = addr;
    bus.M1_HWRITE = wr;
    bus.M1_HSIZE  = size;
    bus.M1_HWDATA = wdata;
  endtask

  task automatic idle_all();
    drive_m0(2'b00, 32'h0, 1'b0, 3'd0, 32'h0);
    drive_m1(2'b00, 32'h0, 1'b0, 3'd0, 32'h0);
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = 32'h0;
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    idle_all();
    HRESET = 1'b1;
    tick();
    tick();
    HRESET = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    HRESET   = 1'b1;
    rr_exp[0] = 32'hA000_0000;
    rr_exp[1] = 32'hB000_0000;
    rr_exp[2] = 32'hA000_0001;
    rr_exp[3] = 32'hB000_0002;
    rr_exp[4] = 32'hA000_0003;
    rr_exp[5] = 32'hB000_0004;

    // ---- reset state, then M0 single read with M1 idle
    do_reset();
    bus.HRESP  = 1'b1;
    bus.HRDATA = 32'h5A5A_A5A5;
    #1;
    check("rst_m0_hready", 32'(bus.M0_HREADY), 32'd1);
    check("rst_m1_hready", 32'(bus.M1_HREADY), 32'd1);
    check("rst_htrans",    32'(bus.HTRANS),    32'd0);
    check("rst_hwdata",    bus.HWDATA,         32'h0);
    check("rst_m0_hresp",  32'(bus.M0_HRESP),  32'd0);
    check("rst_m1_hresp",  32'(bus.M1_HRESP),  32'd0);
    check("hrdata_bcast",  bus.M_HRDATA,       32'h5A5A_A5A5);
    bus.HRESP = 1'b0;
    drive_m0(2'b10, 32'h0200_0000, 1'b0, 3'd2, 32'h1111_1111);
    #1;
    check("s1_htrans", 32'(bus.HTRANS), 32'd2);
    check("s1_haddr",  bus.HADDR,       32'h0200_0000);
    check("s1_hwrite", 32'(bus.HWRITE), 32'd0);
    tick();
    // M0 owns data phase; slave stalls with first ERROR cycle
    drive_m0(2'b00, 32'h0, 1'b0, 3'd0, 32'h1111_1111);
    bus.HREADY = 1'b0;
    bus.HRESP  = 1'b1;
    #1;
    check("s1_dp_m0_hready", 32'(bus.M0_HREADY), 32'd0);
    check("s1_dp_m1_hready", 32'(bus.M1_HREADY), 32'd1);
    check("s1_dp_m0_hresp",  32'(bus.M0_HRESP),  32'd1);
    check("s1_dp_m1_hresp",  32'(bus.M1_HRESP),  32'd0);
    check("s1_dp_hwdata",    bus.HWDATA,         32'h1111_1111);
    check("s1_dp_htrans",    32'(bus.HTRANS),    32'd0);
    tick();
    bus.HREADY = 1'b1;
    #1;
    check("s1_err2_m0_hready", 32'(bus.M0_HREADY), 32'd1);
    check("s1_err2_m0_hresp",  32'(bus.M0_HRESP),  32'd1);
    tick();
    #1;
    check("s1_none_hwdata",   bus.HWDATA,        32'h0);
    check("s1_none_m0_hresp", 32'(bus.M0_HRESP), 32'd0);
    bus.HRESP = 1'b0;

    // ---- simultaneous requests after reset; M0 sends SEQ
    do_reset();
    drive_m0(2'b11, 32'h0C00_0000, 1'b1, 3'd2, 32'h0C0C_0C0C);
    drive_m1(2'b10, 32'h1001_3000, 1'b0, 3'd1, 32'h1010_1010);
    #1;
    check("s2_a_htrans",    32'(bus.HTRANS),    32'd2);
    check("s2_a_haddr",     bus.HADDR,          32'h0C00_0000);
    check("s2_a_hwrite",    32'(bus.HWRITE),    32'd1);
    check("s2_a_m1_hready", 32'(bus.M1_HREADY), 32'd1);
    tick();
    drive_m0(2'b00, 32'h0, 1'b0, 3'd0, 32'h0C0C_0C0C);
    drive_m1(2'b00, 32'hFFFF_FFFF, 1'b1, 3'd0, 32'h1010_1010);
    #1;
    check("s2_b_m1_hready", 32'(bus.M1_HREADY), 32'd0);
    check("s2_b_htrans",    32'(bus.HTRANS),    32'd2);
    check("s2_b_haddr",     bus.HADDR,          32'h1001_3000);
    check("s2_b_hwrite",    32'(bus.HWRITE),    32'd0);
    check("s2_b_hsize",     32'(bus.HSIZE),     32'd1);
    check("s2_b_hwdata",    bus.HWDATA,         32'h0C0C_0C0C);
    tick();
    #1;
    check("s2_c_m1_hready", 32'(bus.M1_HREADY), 32'd1);
    check("s2_c_htrans",    32'(bus.HTRANS),    32'd0);
    check("s2_c_hwdata",    bus.HWDATA,         32'h1010_1010);

    // ---- continuous contention alternates grants
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_m0(2'b10, 32'hA000_0000 + 32'(i), 1'b0, 3'd2, 32'h0);
      drive_m1(2'b10, 32'hB000_0000 + 32'(i), 1'b0, 3'd2, 32'h0);
      #1;
      check($sformatf("s3_haddr_%0d", i), bus.HADDR, rr_exp[i]);
      tick();
    end
    drive_m0(2'b00, 32'h0, 1'b0, 3'd0, 32'h0);
    drive_m1(2'b00, 32'h0, 1'b0, 3'd0, 32'h0);
    #1;
    check("s3_drain_htrans", 32'(bus.HTRANS), 32'd2);
    check("s3_drain_haddr",  bus.HADDR,       32'hA000_0005);

    // ---- slave wait states during M0 data phase while M1 requests
    do_reset();
    drive_m0(2'b10, 32'h0000_4000, 1'b0, 3'd2, 32'h0);
    #1;
    tick();
    drive_m0(2'b00, 32'h0, 1'b0, 3'd0, 32'h0);
    drive_m1(2'b10, 32'h2000_0000, 1'b0, 3'd2, 32'h0);
    bus.HREADY = 1'b0;
    #1;
    check("s4_w1_m1_hready", 32'(bus.M1_HREADY), 32'd1);
    check("s4_w1_m0_hready", 32'(bus.M0_HREADY), 32'd0);
    check("s4_w1_htrans",    32'(bus.HTRANS),    32'd0);
    tick();
    drive_m1(2'b10, 32'h2000_0004, 1'b0, 3'd2, 32'h0);
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("s4_w%0d_m1_hready", i + 2), 32'(bus.M1_HREADY), 32'd0);
      check($sformatf("s4_w%0d_htrans", i + 2),    32'(bus.HTRANS),    32'd0);
      tick();
    end
    bus.HREADY = 1'b1;
    drive_m1(2'b00, 32'h0, 1'b0, 3'd0, 32'h0);
    #1;
    check("s4_go_htrans", 32'(bus.HTRANS), 32'd2);
    check("s4_go_haddr",  bus.HADDR,       32'h2000_0000);

    // ---- M1 write data routing and ERROR isolation
    do_reset();
    drive_m0(2'b00, 32'h0, 1'b0, 3'd0, 32'h1234_5678);
    drive_m1(2'b10, 32'h3000_0000, 1'b1, 3'd2, 32'hDEAD_BEEF);
    #1;
    check("s5_haddr", bus.HADDR, 32'h3000_0000);
    tick();
    drive_m1(2'b00, 32'h0, 1'b0, 3'd0, 32'hDEAD_BEEF);
    bus.HREADY = 1'b0;
    bus.HRESP  = 1'b1;
    #1;
    check("s5_hwdata",    bus.HWDATA,         32'hDEAD_BEEF);
    check("s5_m1_hresp",  32'(bus.M1_HRESP),  32'd1);
    check("s5_m0_hresp",  32'(bus.M0_HRESP),  32'd0);
    check("s5_m1_hready", 32'(bus.M1_HREADY), 32'd0);
    tick();
    bus.HREADY = 1'b1;
    #1;
    check("s5_e2_m1_hresp",  32'(bus.M1_HRESP),  32'd1);
    check("s5_e2_m1_hready", 32'(bus.M1_HREADY), 32'd1);
    tick();
    bus.HRESP = 1'b0;

    // ---- reset while M1 pending and M0 owns data phase
    do_reset();
    drive_m0(2'b10, 32'h0400_0000, 1'b0, 3'd2, 32'h4444_4444);
    drive_m1(2'b10, 32'h0500_0000, 1'b0, 3'd2, 32'h5555_5555);
    #1;
    tick();
    drive_m0(2'b00, 32'h0, 1'b0, 3'd0, 32'h4444_4444);
    drive_m1(2'b00, 32'h0, 1'b0, 3'd0, 32'h5555_5555);
    bus.HREADY = 1'b0;
    #1;
    check("s6_pre_m1_hready", 32'(bus.M1_HREADY), 32'd0);
    check("s6_pre_hwdata",    bus.HWDATA,         32'h4444_4444);
    HRESET = 1'b1;
    tick();
    HRESET     = 1'b0;
    bus.HREADY = 1'b1;
    #1;
    check("s6_m0_hready", 32'(bus.M0_HREADY), 32'd1);
    check("s6_m1_hready", 32'(bus.M1_HREADY), 32'd1);
    check("s6_htrans",    32'(bus.HTRANS),    32'd0);
    check("s6_hwdata",    bus.HWDATA,         32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
